// File: rtl/im_fetch_arb_if.sv
// Bus bundle between the instruction-ROM fetch arbiter and its two read
// requesters (instruction fetch and debug/loader) plus the byte-wide ROM.
interface im_fetch_arb_if #(
    parameter int ROM_AW = 10
);
    // Fetch requester
    logic              if_req;
    logic [11:0]       if_addr;
    logic              if_ack;
    // Debug / loader requester
    logic              dbg_req;
    logic [11:0]       dbg_addr;
    logic              dbg_ack;
    // Shared response word
    logic [31:0]       rdata;
    // Byte-wide synchronous ROM
    logic              rom_rd;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_dout;
    // Status
    logic              busy;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dbg_req, dbg_addr, rom_dout,
        output if_ack, dbg_ack, rdata, rom_rd, rom_addr, busy
    );

    // Requester / ROM side
    modport master (
        output if_req, if_addr, dbg_req, dbg_addr, rom_dout,
        input  if_ack, dbg_ack, rdata, rom_rd, rom_addr, busy
    );
endinterface

// File: rtl/im_fetch_arb.sv
// Round-robin arbiter between instruction fetch and debug reads of a byte-wide
// synchronous ROM. Each transaction reads four consecutive bytes (wrapping at
// the ROM size), assembles them big-endian and acks the granted requester with
// a fixed latency: 4 ISSUE cycles, 1 DRAIN cycle, 1 RESP cycle.
module im_fetch_arb #(
    parameter int ROM_AW = 10
) (
    input  logic            clk,
    input  logic            rst,
    im_fetch_arb_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ROM_AW-1:0] base_q;
    logic [1:0]        cnt_q;
    logic              grant_dbg_q;   // requester of the transaction in flight
    logic              last_dbg_q;    // requester granted most recently
    logic              rom_rd_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic              if_ack_q;
    logic              dbg_ack_q;
    logic              busy_q;
    logic              rd_dly_q;      // a ROM byte arrives this cycle
    logic [31:0]       word_q;

    logic              arb_valid_d;
    logic              arb_dbg_d;
    logic [ROM_AW-1:0] arb_addr_d;
    logic [ROM_AW-1:0] next_addr_d;

    // Arbitration: a lone request wins outright; on a tie the requester that
    // was not granted last time wins, so neither side can be starved.
    always_comb begin
        arb_valid_d = bus.if_req | bus.dbg_req;
        if (bus.if_req && bus.dbg_req) begin
            arb_dbg_d = ~last_dbg_q;
        end else begin
            arb_dbg_d = bus.dbg_req;
        end
        arb_addr_d = arb_dbg_d ? bus.dbg_addr[ROM_AW-1:0] : bus.if_addr[ROM_AW-1:0];
    end

    // Byte address for the next ISSUE cycle; natural overflow gives the wrap.
    assign next_addr_d = base_q + ROM_AW'(cnt_q) + ROM_AW'(1);

    // Control FSM with registered ROM strobe, acks and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            cnt_q       <= 2'd0;
            grant_dbg_q <= 1'b0;
            last_dbg_q  <= 1'b1;
            rom_rd_q    <= 1'b0;
            rom_addr_q  <= '0;
            if_ack_q    <= 1'b0;
            dbg_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if_ack_q  <= 1'b0;
            dbg_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_valid_d) begin
                        state_q     <= ISSUE;
                        base_q      <= arb_addr_d;
                        grant_dbg_q <= arb_dbg_d;
                        last_dbg_q  <= arb_dbg_d;
                        cnt_q       <= 2'd0;
                        rom_rd_q    <= 1'b1;
                        rom_addr_q  <= arb_addr_d;
                        busy_q      <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (cnt_q == 2'd3) begin
                        state_q    <= DRAIN;
                        rom_rd_q   <= 1'b0;
                        rom_addr_q <= '0;
                    end else begin
                        cnt_q      <= cnt_q + 2'd1;
                        rom_addr_q <= next_addr_d;
                    end
                end
                DRAIN: begin
                    // Last byte is shifted in at the end of this cycle, so the
                    // word is complete when the ack goes out in RESP.
                    state_q   <= RESP;
                    if_ack_q  <= ~grant_dbg_q;
                    dbg_ack_q <= grant_dbg_q;
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Word assembly: shift in one ROM byte in every cycle following a read
    // strobe; the byte at base ends up in bits [31:24].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_dly_q <= 1'b0;
            word_q   <= 32'd0;
        end else begin
            rd_dly_q <= rom_rd_q;
            if (rd_dly_q) begin
                word_q <= {word_q[23:0], bus.rom_dout};
            end
        end
    end

    // Address bits above the ROM size are intentionally ignored.
    generate
        if (ROM_AW < 12) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^{bus.if_addr[11:ROM_AW], bus.dbg_addr[11:ROM_AW]};
        end
    endgenerate

    assign bus.rom_rd   = rom_rd_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.if_ack   = if_ack_q;
    assign bus.dbg_ack  = dbg_ack_q;
    assign bus.rdata    = word_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_im_fetch_arb.sv
// Bench for im_fetch_arb: table of directed transactions, hand-written
// round-robin and reset-abort sequences, then random traffic against a
// transaction-level reference model.
module tb_im_fetch_arb;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    im_fetch_arb_if #(.ROM_AW(AW)) bus();

    im_fetch_arb #(.ROM_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM model
    logic [7:0] rom [0:1023];
    always @(posedge clk) begin
        if (bus.rom_rd) bus.rom_dout <= rom[bus.rom_addr];
    end

    int checks = 0;
    int errors = 0;
    logic [9:0] addr_log[$];

    typedef struct {
        bit          use_if;
        bit          use_dbg;
        logic [11:0] ia;
        logic [11:0] da;
        bit          first_dbg;
        logic [31:0] d1;
        logic [31:0] d2;
    } vec_t;

    vec_t vecs[5];

    // Shared bench variables
    int          nack, t1, t2, nexp, ovl, dbg_cnt, idle_cnt, steps;
    bit          w1, w2;
    logic [31:0] r1, r2;
    int          at_t[6];
    bit          at_who[6];
    logic [31:0] at_dat[6];
    logic [11:0] b1, b2;

    // Random-phase model state
    int          ack_at, busy_lo, busy_hi, next_free, if_gap, dbg_gap;
    bit          ack_dbg, last_dbg, pick_dbg, exp_if, exp_dbg, exp_busy;
    logic [31:0] ack_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Expected word: four bytes from the byte address, wrapping at ROM size.
    function automatic logic [31:0] ref_word(input logic [11:0] a);
        int b;
        b = int'(a) % 1024;
        return {rom[b], rom[(b + 1) % 1024], rom[(b + 2) % 1024], rom[(b + 3) % 1024]};
    endfunction

    task automatic step();
        @(negedge clk);
        if (bus.rom_rd) addr_log.push_back(bus.rom_addr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.if_req = 1'b0;
        bus.dbg_req = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", {18'd0, bus.if_ack, bus.dbg_ack, bus.rom_rd, bus.busy, bus.rom_addr}, 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        rst = 1'b0;
        addr_log.delete();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = i[7:0];
        rom[12'h010] = 8'h12; rom[12'h011] = 8'h34; rom[12'h012] = 8'h56; rom[12'h013] = 8'h78;
        rom[12'h3FF] = 8'hAA; rom[12'h000] = 8'hBB; rom[12'h001] = 8'hCC; rom[12'h002] = 8'hDD;

        vecs[0] = '{1'b1, 1'b0, 12'h010, 12'h000, 1'b0, 32'h12345678, 32'h00000000};
        vecs[1] = '{1'b0, 1'b1, 12'h000, 12'hBFF, 1'b1, 32'hAABBCCDD, 32'h00000000};
        vecs[2] = '{1'b1, 1'b1, 12'h000, 12'h004, 1'b0, 32'hBBCCDD03, 32'h04050607};
        vecs[3] = '{1'b1, 1'b0, 12'h40F, 12'h000, 1'b0, 32'h0F123456, 32'h00000000};
        vecs[4] = '{1'b1, 1'b1, 12'hFFE, 12'h0FE, 1'b0, 32'hFEAABBCC, 32'hFEFF0001};

        bus.if_req = 1'b0; bus.dbg_req = 1'b0;
        bus.if_addr = 12'h000; bus.dbg_addr = 12'h000;

        // ---------------- Table-driven transactions ----------------
        for (int r = 0; r < 5; r++) begin
            do_reset();
            bus.if_addr  = vecs[r].ia;
            bus.dbg_addr = vecs[r].da;
            bus.if_req   = vecs[r].use_if;
            bus.dbg_req  = vecs[r].use_dbg;
            nack = 0; t1 = -1; t2 = -1; ovl = 0;
            w1 = 1'b0; w2 = 1'b0; r1 = '0; r2 = '0;
            for (int c = 1; c <= 20; c++) begin
                step();
                if (bus.if_ack && bus.dbg_ack) ovl = 1;
                if (bus.if_ack || bus.dbg_ack) begin
                    if (nack == 0) begin t1 = c; w1 = bus.dbg_ack; r1 = bus.rdata; end
                    else if (nack == 1) begin t2 = c; w2 = bus.dbg_ack; r2 = bus.rdata; end
                    nack++;
                    if (bus.if_ack) bus.if_req = 1'b0;
                    if (bus.dbg_ack) bus.dbg_req = 1'b0;
                end
            end
            nexp = int'(vecs[r].use_if) + int'(vecs[r].use_dbg);
            chk($sformatf("vec%0d_acks", r), nack, nexp);
            chk($sformatf("vec%0d_t1", r), t1, 6);
            chk($sformatf("vec%0d_who1", r), 32'(w1), 32'(vecs[r].first_dbg));
            chk($sformatf("vec%0d_data1", r), r1, vecs[r].d1);
            chk($sformatf("vec%0d_overlap", r), ovl, 0);
            chk($sformatf("vec%0d_nrd", r), addr_log.size(), 4 * nexp);
            b1 = vecs[r].first_dbg ? vecs[r].da : vecs[r].ia;
            b2 = vecs[r].first_dbg ? vecs[r].ia : vecs[r].da;
            for (int k = 0; k < 4; k++)
                chk($sformatf("vec%0d_addr%0d", r, k), 32'(addr_log[k]), 32'((int'(b1) + k) % 1024));
            if (nexp == 2) begin
                chk($sformatf("vec%0d_t2", r), t2, 13);
                chk($sformatf("vec%0d_who2", r), 32'(w2), 32'(!vecs[r].first_dbg));
                chk($sformatf("vec%0d_data2", r), r2, vecs[r].d2);
                for (int k = 0; k < 4; k++)
                    chk($sformatf("vec%0d_addr%0d", r, k + 4), 32'(addr_log[k + 4]),
                        32'((int'(b2) + k) % 1024));
            end
            $display("vec %0d: acks=%0d t1=%0d data1=%h t2=%0d data2=%h", r, nack, t1, r1, t2, r2);
        end

        // ---------------- Both requesters held high: alternation ----------------
        do_reset();
        bus.if_addr = 12'h020; bus.dbg_addr = 12'h030;
        bus.if_req = 1'b1; bus.dbg_req = 1'b1;
        nack = 0; idle_cnt = 0; steps = 0;
        while (nack < 6 && steps < 80) begin
            step();
            steps++;
            if (nack > 0 && !bus.busy) idle_cnt++;
            if (bus.if_ack || bus.dbg_ack) begin
                at_t[nack] = steps; at_who[nack] = bus.dbg_ack; at_dat[nack] = bus.rdata;
                nack++;
            end
        end
        bus.if_req = 1'b0; bus.dbg_req = 1'b0;
        chk("rr_acks", nack, 6);
        chk("rr_first_t", at_t[0], 6);
        chk("rr_idle_cycles", idle_cnt, 5);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr_who%0d", k), 32'(at_who[k]), 32'(k % 2));
            chk($sformatf("rr_data%0d", k), at_dat[k], ref_word((k % 2 == 1) ? 12'h030 : 12'h020));
            if (k > 0) chk($sformatf("rr_gap%0d", k), at_t[k] - at_t[k - 1], 7);
            $display("rr %0d: who=%s t=%0d data=%h", k, at_who[k] ? "DBG" : "IF", at_t[k], at_dat[k]);
        end

        // ---------------- Reset during the third ISSUE cycle ----------------
        do_reset();
        bus.if_addr = 12'h010; bus.if_req = 1'b1;
        step(); step(); step();
        chk("abort_pre_busy", 32'({bus.busy, bus.rom_rd}), 32'd3);
        rst = 1'b1;
        #1;
        chk("abort_rst_ctrl", {18'd0, bus.if_ack, bus.dbg_ack, bus.rom_rd, bus.busy, bus.rom_addr}, 32'd0);
        chk("abort_rst_rdata", bus.rdata, 32'd0);
        step();
        rst = 1'b0;
        nack = 0; t1 = -1; r1 = '0; dbg_cnt = 0;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (bus.dbg_ack) dbg_cnt++;
            if (bus.if_ack) begin
                nack++;
                if (t1 < 0) begin t1 = c; r1 = bus.rdata; bus.if_req = 1'b0; end
            end
        end
        chk("abort_acks", nack, 1);
        chk("abort_t", t1, 6);
        chk("abort_data", r1, 32'h12345678);
        chk("abort_dbg_acks", dbg_cnt, 0);
        $display("abort: acks=%0d t=%0d data=%h", nack, t1, r1);

        // ---------------- Random traffic vs transaction-level model ----------------
        do_reset();
        ack_at = -100; busy_lo = -100; busy_hi = -100; next_free = 0;
        last_dbg = 1'b1; ack_dbg = 1'b0; ack_data = '0;
        if_gap = 0; dbg_gap = 0;
        for (int c = 0; c < 700; c++) begin
            exp_if   = (c == ack_at) && !ack_dbg;
            exp_dbg  = (c == ack_at) && ack_dbg;
            exp_busy = (c >= busy_lo) && (c <= busy_hi);
            chk("rnd_if_ack", 32'(bus.if_ack), 32'(exp_if));
            chk("rnd_dbg_ack", 32'(bus.dbg_ack), 32'(exp_dbg));
            chk("rnd_busy", 32'(bus.busy), 32'(exp_busy));
            if (c == ack_at) begin
                chk("rnd_rdata", bus.rdata, ack_data);
                $display("rnd c=%0d: %s ack data=%h", c, ack_dbg ? "DBG" : "IF", bus.rdata);
            end
            // Requesters: drop on ack, re-request after a random gap
            if (exp_if) begin
                bus.if_req = 1'b0; if_gap = $urandom_range(0, 3);
            end else if (!bus.if_req) begin
                if (if_gap == 0) begin bus.if_req = 1'b1; bus.if_addr = 12'($urandom); end
                else if_gap--;
            end
            if (exp_dbg) begin
                bus.dbg_req = 1'b0; dbg_gap = $urandom_range(0, 3);
            end else if (!bus.dbg_req) begin
                if (dbg_gap == 0) begin bus.dbg_req = 1'b1; bus.dbg_addr = 12'($urandom); end
                else dbg_gap--;
            end
            // Model: the arbiter accepts at the next edge once free
            if (c >= next_free && (bus.if_req || bus.dbg_req)) begin
                pick_dbg  = (bus.if_req && bus.dbg_req) ? !last_dbg : bus.dbg_req;
                last_dbg  = pick_dbg;
                ack_dbg   = pick_dbg;
                ack_data  = ref_word(pick_dbg ? bus.dbg_addr : bus.if_addr);
                ack_at    = c + 6;
                busy_lo   = c + 1;
                busy_hi   = c + 6;
                next_free = c + 7;
            end
            step();
        end
        bus.if_req = 1'b0; bus.dbg_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
